mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access unit of the five-stage pipeline, sitting directly upstream of the MEM/WB pipeline register. It turns the EX/MEM load/store request into a variable-latency request/acknowledge transaction on the data-memory bus. It generates byte enables and replicated store data, and sign- or zero-extends load data into the word MEM/WB captures as DM data. It stalls the upstream pipeline until the bus acknowledges.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width on both the pipeline and bus sides.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  a live instruction occupies the MEM stage.
- `mem_op_i`  in  4  operation code from `mem_pkg`: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
- `addr_i`  in  ADDR_W  effective byte address, which is the ALU result.
- `wdata_i`  in  32  store data, which is the forwarded rt value.
- `stall_o`  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- `bubble_o`  out  1  MEM/WB must load a NOP this cycle.
- `rdata_o`  out  32  extended load result, feeding MEM/WB DM data.
- `addr_err_o`  out  1  misaligned access detected.
- `bus_req_o`  out  1  bus request.
- `bus_we_o`  out  1  write strobe, 1 for stores.
- `bus_addr_o`  out  ADDR_W  word-aligned address, with [1:0] forced to 0.
- `bus_be_o`  out  4  byte enables, where bit i covers bits [8i+7:8i].
- `bus_wdata_o`  out  32  replicated store data.
- `bus_ack_i`  in  1  single-cycle completion pulse.
- `bus_rdata_i`  in  32  read data, valid only in the ack cycle.

## Operation
FSM states are IDLE, REQ and DONE.
- **IDLE:**
  - An access is accepted when `valid_i`=1, the op is not NONE, and the access is aligned.
  - On acceptance, register the bus address, we, be and wdata, then go to REQ.
  - Otherwise stay in IDLE.
- **REQ:**
  - `bus_req_o`=1. Address, we, be and wdata stay stable until ack.
  - On `bus_ack_i`, register the extended load data (stores leave `rdata_o` unchanged) and go to DONE.
- **DONE:**
  - Lasts exactly one cycle. Inputs are ignored, so the same instruction is not reissued.
  - Then return to IDLE.
- **Misalignment:**
  - LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - `addr_err_o`=1, combinational, in IDLE while `valid_i`.
  - No request is issued, the store is suppressed, and there is no stall.
- **Byte enables and store data:**
  - SW: be=1111, data=wdata.
  - SH: be=1100 if addr[1]=1, else 0011; data={wdata[15:0], wdata[15:0]}.
  - SB: be=0001<<addr[1:0]; data is wdata[7:0] replicated four times.
  - Loads: be=1111, we=0.
- **Load extension (little-endian):**
  - LB/LBU select byte addr[1:0].
  - LH/LHU select halfword addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- **Non-memory ops:** no stall, and `rdata_o` holds its last value.

## Timing
- **Reset values:** state=IDLE, every output 0, including `rdata_o`.
- **stall_o:**
  - Combinational.
  - Equals 1 in IDLE when an access is accepted.
  - Equals 1 throughout REQ.
  - Equals 0 in DONE.
- **bubble_o:** equals `stall_o`.
- **Latency:** an ack N cycles after REQ entry (N≥0) gives N+2 stall cycles.
  - The result is visible on `rdata_o` in the DONE cycle and is captured by MEM/WB at the end of DONE.
- **bus_ack_i outside REQ:** ignored.
- **Reset asserted mid-transaction:**
  - Immediate return to IDLE, and `bus_req_o` drops asynchronously.
  - An ack arriving after reset release, before any new request, is ignored.
- **Bus rules:**
  - At most one outstanding request.
  - `bus_req_o` never deasserts without an ack, except on reset.

## Structure
- `mem_pkg` holds:
  - the `mem_op_t` encodings;
  - the `state_t` enum (IDLE/REQ/DONE);
  - width constants.
- Sub-module `load_ext` holds the combinational byte/halfword select and sign/zero extension, with inputs rdata, addr[1:0] and op, and a 32-bit output.
- Byte-enable and replication logic stays inline.

## Test plan
1. **Zero-wait load:**
   - Stimulus: LW at addr 0x10, ack in the first REQ cycle with rdata 0xDEADBEEF.
   - Response: `stall_o` high for 2 cycles, `bus_be_o`=1111, `rdata_o`=0xDEADBEEF in DONE.
2. **Byte loads:**
   - Stimulus: LB at 0x13 with rdata 0x80FF0000; then LBU with the same data.
   - Response: `rdata_o`=0xFFFFFF80 for LB, then 0x00000080 for LBU.
3. **Halfword store:**
   - Stimulus: SH at 0x22 with wdata 0x1234ABCD.
   - Response: `bus_addr_o`=0x20, `bus_be_o`=1100, `bus_wdata_o`=0xABCDABCD, `bus_we_o`=1.
4. **Misaligned load:**
   - Stimulus: LW at 0x06.
   - Response: `addr_err_o`=1, no `bus_req_o`, `stall_o`=0.
5. **Delayed ack:**
   - Stimulus: LH at 0x02, ack after 5 wait cycles with rdata 0x8001xxxx.
   - Response: 7 stall cycles, bus outputs stable throughout, `rdata_o`=0xFFFF8001.
6. **Reset during REQ:**
   - Stimulus: assert reset while in REQ, release it, then pulse ack.
   - Response: `bus_req_o`=0 immediately, the ack is ignored, `stall_o`=0, `rdata_o`=0.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the memory-stage access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        NONE = 4'd0,
        LW   = 4'd1,
        LH   = 4'd2,
        LHU  = 4'd3,
        LB   = 4'd4,
        LBU  = 4'd5,
        SW   = 4'd6,
        SH   = 4'd7,
        SB   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
        case (op)
            LW, SW:       return lo != 2'b00;
            LH, LHU, SH:  return lo[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_ext.sv
// ============================================================================
// Module      : load_ext
// Description : Little-endian byte/halfword select with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_ext
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        addr_lo_i,
    input  mem_op_t           op_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (op_i)
            LB:      data_o = {{24{w_byte[7]}}, w_byte};
            LBU:     data_o = {24'd0, w_byte};
            LH:      data_o = {{16{w_half[15]}}, w_half};
            LHU:     data_o = {16'd0, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit driving a req/ack data-memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [OP_W-1:0]   mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              addr_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [BE_W-1:0]   bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_we_q, bus_we_d;
    logic [BE_W-1:0]     bus_be_q, bus_be_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    mem_op_t             op_q, op_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    mem_op_t             w_op;
    logic                w_is_mem;
    logic                w_misaligned;
    logic                w_accept;
    logic [BE_W-1:0]     w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_ext;

    // Unused opcode values fall out as neither load nor store and are never accepted.
    assign w_op         = mem_op_t'(mem_op_i);
    assign w_is_mem     = is_load(w_op) || is_store(w_op);
    assign w_misaligned = w_is_mem && is_misaligned(w_op, addr_i[1:0]);
    assign w_accept     = (state_q == IDLE) && valid_i && w_is_mem && !w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
        case (w_op)
            SH: begin
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_i[15:0]}};
            end
            SB: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

    load_ext u_load_ext (
        .rdata_i   (bus_rdata_i),
        .addr_lo_i (addr_lo_q),
        .op_i      (op_q),
        .data_o    (w_ext)
    );

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d     = REQ;
                    bus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                    bus_we_d    = is_store(w_op);
                    bus_be_d    = w_be;
                    bus_wdata_d = w_wdata;
                    op_d        = w_op;
                    addr_lo_d   = addr_i[1:0];
                end
            end
            REQ: begin
                if (bus_ack_i) begin
                    state_d = DONE;
                    if (is_load(op_q)) begin
                        rdata_d = w_ext;
                    end
                end
            end
            // One-cycle hold so the stalled instruction is not re-accepted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            op_q        <= NONE;
            addr_lo_q   <= 2'b00;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            rdata_q     <= rdata_d;
        end
    end

    assign stall_o     = w_accept || (state_q == REQ);
    assign bubble_o    = stall_o;
    assign addr_err_o  = (state_q == IDLE) && valid_i && w_misaligned;
    assign bus_req_o   = (state_q == REQ);
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;
    assign rdata_o     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  mem_op_i = 4'd0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_o, bubble_o, addr_err_o, bus_req_o, bus_we_o;
    logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_rdata = '0;

    int          o_stall, o_req;
    logic        o_err, o_we, o_stable, o_bub_ok;
    logic [31:0] o_addr, o_wd, o_rdata;
    logic [3:0]  o_be;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .mem_op_i    (mem_op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .bubble_o    (bubble_o),
        .rdata_o     (rdata_o),
        .addr_err_o  (addr_err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_misaligned(input mem_op_t op, input logic [31:0] a);
        if (op == LW || op == SW) return (a % 4) != 0;
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic bit m_is_mem(input mem_op_t op);
        return op inside {LW, LH, LHU, LB, LBU, SW, SH, SB};
    endfunction

    function automatic bit m_is_store(input mem_op_t op);
        return op inside {SW, SH, SB};
    endfunction

    function automatic logic [3:0] m_be(input mem_op_t op, input logic [31:0] a);
        logic [31:0] one;
        one = 32'd1;
        if (op == SB) return 4'(one << (a % 4));
        if (op == SH) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input mem_op_t op, input logic [31:0] wd);
        if (op == SB) return (wd % 256) * 32'h0101_0101;
        if (op == SH) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ext(input mem_op_t op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (op == LB || op == LBU) begin
            v = (rd >> (8 * (a % 4))) % 256;
            if (op == LB && v >= 128) v = v - 256;
            return v;
        end
        if (op == LH || op == LHU) begin
            v = (rd >> (16 * ((a / 2) % 2))) % 65536;
            if (op == LH && v >= 32768) v = v - 65536;
            return v;
        end
        return rd;
    endfunction

    // ---------------- transaction driver (observes only) ----------------
    task automatic run_access(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                              input int delay, input logic [31:0] rd);
        bit first;
        o_stall = 0; o_req = 0; o_err = 0; o_stable = 1'b1; o_bub_ok = 1'b1;
        o_addr = '0; o_be = '0; o_wd = '0; o_we = 1'b0; o_rdata = '0;
        @(posedge clk); #1;
        valid_i = 1'b1; mem_op_i = op; addr_i = a; wdata_i = wd;
        @(negedge clk);
        o_err = addr_err_o;
        if (bubble_o !== stall_o) o_bub_ok = 1'b0;
        if (bus_req_o) o_req++;
        if (!stall_o) begin
            o_rdata = rdata_o;
            @(posedge clk); #1;
            valid_i = 1'b0; mem_op_i = 4'(NONE);
            return;
        end
        o_stall++;
        @(posedge clk); #1;
        first = 1'b1;
        for (int k = 0; k <= delay; k++) begin
            bus_ack_i   = (k == delay);
            bus_rdata_i = (k == delay) ? rd : $urandom;
            @(negedge clk);
            if (stall_o) o_stall++;
            if (bus_req_o) o_req++;
            if (bubble_o !== stall_o) o_bub_ok = 1'b0;
            if (first) begin
                o_addr = bus_addr_o; o_be = bus_be_o; o_wd = bus_wdata_o; o_we = bus_we_o;
                first = 1'b0;
            end else if (o_addr !== bus_addr_o || o_be !== bus_be_o ||
                         o_wd !== bus_wdata_o || o_we !== bus_we_o) begin
                o_stable = 1'b0;
            end
            @(posedge clk); #1;
            bus_ack_i = 1'b0;
        end
        @(negedge clk);
        if (stall_o) o_stall++;
        if (bus_req_o) o_req++;
        if (bubble_o !== stall_o) o_bub_ok = 1'b0;
        o_rdata = rdata_o;
        valid_i = 1'b0; mem_op_i = 4'(NONE);
        @(posedge clk); #1;
    endtask

    // ---------------- feature tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({stall_o, bubble_o, addr_err_o, bus_req_o, bus_we_o} !== 5'b0 ||
            rdata_o !== 32'd0 || bus_addr_o !== 32'd0 || bus_be_o !== 4'd0 || bus_wdata_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: stall=%b req=%b we=%b rdata=%h addr=%h be=%b wd=%h, required all zero",
                     stall_o, bus_req_o, bus_we_o, rdata_o, bus_addr_o, bus_be_o, bus_wdata_o);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_rdata = '0;
    endtask

    task automatic test_zero_wait_load;
        run_access(LW, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        vectors++;
        if (o_stall !== 2) begin miscompares++; $display("FAIL zw_stall_cycles: got %0d required 2", o_stall); end
        vectors++;
        if (o_be !== 4'hF || o_we !== 1'b0 || o_addr !== 32'h10) begin
            miscompares++; $display("FAIL zw_bus: be=%b we=%b addr=%h required 1111/0/00000010", o_be, o_we, o_addr);
        end
        vectors++;
        if (o_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL zw_rdata: got %h required deadbeef", o_rdata); end
        model_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_byte_loads;
        run_access(LB, 32'h13, 32'h0, 1, 32'h80FF0000);
        vectors++;
        if (o_rdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_rdata: got %h required ffffff80", o_rdata); end
        run_access(LBU, 32'h13, 32'h0, 0, 32'h80FF0000);
        vectors++;
        if (o_rdata !== 32'h00000080) begin miscompares++; $display("FAIL lbu_rdata: got %h required 00000080", o_rdata); end
        model_rdata = 32'h00000080;
    endtask

    task automatic test_halfword_store;
        run_access(SH, 32'h22, 32'h1234ABCD, 2, 32'h5555AAAA);
        vectors++;
        if (o_addr !== 32'h20 || o_be !== 4'b1100 || o_wd !== 32'hABCDABCD || o_we !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_bus: addr=%h be=%b wd=%h we=%b required 00000020/1100/abcdabcd/1", o_addr, o_be, o_wd, o_we);
        end
        vectors++;
        if (o_rdata !== model_rdata) begin miscompares++; $display("FAIL sh_rdata_hold: got %h required %h", o_rdata, model_rdata); end
    endtask

    task automatic test_misaligned;
        run_access(LW, 32'h06, 32'h0, 0, 32'h0);
        vectors++;
        if (o_err !== 1'b1 || o_req !== 0 || o_stall !== 0) begin
            miscompares++; $display("FAIL misaligned_lw: err=%b req=%0d stall=%0d required 1/0/0", o_err, o_req, o_stall);
        end
    endtask

    task automatic test_delayed_ack;
        run_access(LH, 32'h02, 32'h0, 5, 32'h80015A5A);
        vectors++;
        if (o_stall !== 7) begin miscompares++; $display("FAIL delayed_stall_cycles: got %0d required 7", o_stall); end
        vectors++;
        if (o_stable !== 1'b1 || o_addr !== 32'h0 || o_be !== 4'hF) begin
            miscompares++; $display("FAIL delayed_bus_stable: stable=%b addr=%h be=%b required 1/00000000/1111", o_stable, o_addr, o_be);
        end
        vectors++;
        if (o_rdata !== 32'hFFFF8001) begin miscompares++; $display("FAIL delayed_rdata: got %h required ffff8001", o_rdata); end
        model_rdata = 32'hFFFF8001;
    endtask

    task automatic test_ack_outside_req;
        @(posedge clk); #1;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h13579BDF;
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (rdata_o !== model_rdata || bus_req_o !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++; $display("FAIL idle_ack_ignored: rdata=%h req=%b stall=%b required %h/0/0", rdata_o, bus_req_o, stall_o, model_rdata);
        end
    endtask

    task automatic test_random;
        mem_op_t     op;
        logic [31:0] a, wd, rd, exp_rd;
        int          d;
        bit          acc;
        for (int n = 0; n < 60; n++) begin
            op = mem_op_t'($urandom_range(0, 8));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) * 2);
            wd = $urandom; rd = $urandom; d = $urandom_range(0, 4);
            acc = m_is_mem(op) && !m_misaligned(op, a);
            exp_rd = (acc && !m_is_store(op)) ? m_ext(op, a, rd) : model_rdata;
            run_access(op, a, wd, d, rd);
            vectors++;
            if (o_err !== (m_is_mem(op) && m_misaligned(op, a)) || o_bub_ok !== 1'b1) begin
                miscompares++; $display("FAIL rnd_err_bubble[%0d]: op=%0d addr=%h err=%b bub_ok=%b", n, op, a, o_err, o_bub_ok);
            end
            vectors++;
            if (o_stall !== (acc ? d + 2 : 0) || o_req !== (acc ? d + 1 : 0)) begin
                miscompares++; $display("FAIL rnd_stall[%0d]: op=%0d stall=%0d req=%0d required %0d/%0d", n, op, o_stall, o_req,
                                        acc ? d + 2 : 0, acc ? d + 1 : 0);
            end
            if (acc) begin
                vectors++;
                if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(op, a) || o_we !== m_is_store(op) || o_stable !== 1'b1 ||
                    (m_is_store(op) && o_wd !== m_wd(op, wd))) begin
                    miscompares++;
                    $display("FAIL rnd_bus[%0d]: op=%0d addr=%h be=%b we=%b wd=%h stable=%b required %h/%b/%b/%h/1", n, op, o_addr,
                             o_be, o_we, o_wd, o_stable, {a[31:2], 2'b00}, m_be(op, a), m_is_store(op), m_wd(op, wd));
                end
            end
            vectors++;
            if (o_rdata !== exp_rd) begin
                miscompares++; $display("FAIL rnd_rdata[%0d]: op=%0d addr=%h got %h required %h", n, op, a, o_rdata, exp_rd);
            end
            model_rdata = exp_rd;
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        valid_i = 1'b1; mem_op_i = 4'(LW); addr_i = 32'h40;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (bus_req_o !== 1'b1) begin miscompares++; $display("FAIL rm_in_req: req=%b required 1", bus_req_o); end
        #2;
        reset = 1'b0; valid_i = 1'b0; mem_op_i = 4'(NONE);
        #1;
        vectors++;
        if (bus_req_o !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++; $display("FAIL rm_async_drop: req=%b stall=%b required 0/0", bus_req_o, stall_o);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'd0) begin
            miscompares++; $display("FAIL rm_ack_ignored: req=%b stall=%b rdata=%h required 0/0/00000000", bus_req_o, stall_o, rdata_o);
        end
        model_rdata = '0;
    endtask

    initial begin
        test_reset;
        test_zero_wait_load;
        test_byte_loads;
        test_halfword_store;
        test_misaligned;
        test_delayed_ack;
        test_ack_outside_req;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
